// File: rtl/alu_pkg.sv
// Shared ALU definitions: default result width, source slot indices and the
// occupancy encoding used by the result skid buffer.
package alu_pkg;

  localparam int ALU_WIDTH    = 64;
  localparam int ALU_SRC_CMP  = 0;
  localparam int ALU_SRC_PASS = 1;
  localparam int ALU_SRC_XOR  = 2;
  localparam int ALU_SRC_ADD  = 3;
  localparam int ALU_NUM_SRC  = 4;

  // Occupancy of the 2-entry skid buffer: nothing, main only, main and skid.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_result_mux_pipe_if.sv
// Bus between the ALU source side and the result selector pipeline.
// Optional macro ALU_RESULT_MUX_ZERO_FLAG_EN adds the zero_o flag.
interface alu_result_mux_pipe_if #(
  parameter int WIDTH   = 64,
  parameter int NUM_SRC = 4
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC*WIDTH-1:0] srcs_i;
  logic [SEL_W-1:0]         sel_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [WIDTH-1:0]         result_o;
  logic                     err_o;
  logic                     valid_o;
  logic                     ready_i;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
  logic                     zero_o;
`endif

  // Source side: drives beats and downstream ready, observes results.
  modport master (
    output srcs_i, sel_i, valid_i, ready_i,
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
    input  zero_o,
`endif
    input  ready_o, result_o, err_o, valid_o
  );

  // Pipeline side: consumes beats, presents results.
  modport slave (
    input  srcs_i, sel_i, valid_i, ready_i,
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
    output zero_o,
`endif
    output ready_o, result_o, err_o, valid_o
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready_o and out_valid_o come
// straight from flops, so neither handshake side sees a combinational path.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_r;
  skid_state_e      state_nxt_s;
  logic             valid_r;
  logic             ready_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             accept_s;
  logic             emit_s;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  assign accept_s    = in_valid_i & ready_r;
  assign emit_s      = valid_r & out_ready_i;
  assign in_ready_o  = ready_r;
  assign out_valid_o = valid_r;
  assign out_data_o  = main_r;

  // Occupancy register; valid/ready flags are registered decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= SKID_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != SKID_EMPTY);
      ready_r <= (state_nxt_s != SKID_TWO);
    end
  end

  // Next occupancy from the accept/emit handshakes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SKID_EMPTY: state_nxt_s = accept_s ? SKID_ONE : SKID_EMPTY;
      SKID_ONE: begin
        if (accept_s && !emit_s) begin
          state_nxt_s = SKID_TWO;
        end else if (!accept_s && emit_s) begin
          state_nxt_s = SKID_EMPTY;
        end else begin
          state_nxt_s = SKID_ONE;
        end
      end
      SKID_TWO:   state_nxt_s = emit_s ? SKID_ONE : SKID_TWO;
      default:    state_nxt_s = SKID_EMPTY;
    endcase
  end

  // Datapath steering: fresh beat into main or skid, or skid forward into main.
  always_comb begin
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      SKID_EMPTY: load_main_in_s = accept_s;
      SKID_ONE: begin
        load_main_in_s = accept_s & emit_s;
        load_skid_s    = accept_s & ~emit_s;
      end
      SKID_TWO:   load_main_skid_s = emit_s;
      default: begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
      end
    endcase
  end

  // Payload storage; main holds steady while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_r <= {WIDTH{1'b0}};
      skid_r <= {WIDTH{1'b0}};
    end else begin
      if (load_main_in_s) begin
        main_r <= in_data_i;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data_i;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

endmodule

// File: rtl/alu_result_mux_pipe.sv
// Registered ALU result selector: picks one of NUM_SRC result buses and
// presents it through a 2-entry skid buffer. Out-of-range selects produce a
// zero result with err_o set. Optional macro ALU_RESULT_MUX_ZERO_FLAG_EN adds
// a registered zero_o flag travelling with each beat.
module alu_result_mux_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int NUM_SRC = ALU_NUM_SRC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_result_mux_pipe_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_SRC);
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("alu_result_mux_pipe: NUM_SRC must be within 2..16");
  end

  logic [WIDTH-1:0] sel_data_s;
  logic             sel_hit_s;
  logic [PW-1:0]    in_payload_s;
  logic [PW-1:0]    out_payload_s;

  // Source selector: one-hot match over legal indices, so an out-of-range
  // select matches nothing and yields zero data with the error flag.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    sel_hit_s  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data_s = sel_data_s |
                   ((bus.sel_i == SEL_W'(k)) ? bus.srcs_i[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
      sel_hit_s  = sel_hit_s | (bus.sel_i == SEL_W'(k));
    end
  end

`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
  assign in_payload_s = {(sel_data_s == {WIDTH{1'b0}}), ~sel_hit_s, sel_data_s};
  assign bus.zero_o   = out_payload_s[WIDTH+1];
`else
  assign in_payload_s = {~sel_hit_s, sel_data_s};
`endif
  assign bus.result_o = out_payload_s[WIDTH-1:0];
  assign bus.err_o    = out_payload_s[WIDTH];

  alu_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (bus.valid_i),
    .in_ready_o  (bus.ready_o),
    .in_data_i   (in_payload_s),
    .out_valid_o (bus.valid_o),
    .out_ready_i (bus.ready_i),
    .out_data_o  (out_payload_s)
  );

endmodule

// File: doc/alu_result_mux_pipe.md
Name: alu_result_mux_pipe

Overview:
- Parametrised, registered successor to the ALU output selector.
- Selects one of NUM_SRC result buses (comparator, passthrough, xor, adder, future units) of WIDTH bits.
- Presents the selected result through a valid/ready output stage with a 2-entry skid buffer, so the ALU can be pipelined toward the Skein round logic without combinational ready paths.
- Out-of-range selects are flagged, not silently aliased.

Parameters:
- WIDTH, 64: width of each source and of the result.
- NUM_SRC, 4: number of source buses; legal range 2..16.
- SEL_W, $clog2(NUM_SRC): select width (derived localparam, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- srcs_i  input  NUM_SRC*WIDTH  concatenated sources; source k at bits [k*WIDTH +: WIDTH].
- sel_i  input  SEL_W  source index, sampled with valid_i.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  block can accept a beat.
- result_o  output  WIDTH  selected result.
- err_o  output  1  beat carried an out-of-range select; travels with result_o.
- valid_o  output  1  result_o/err_o valid.
- ready_i  input  1  downstream accepts.

Behaviour:
- Clocking: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: valid_o=0, result_o=0, err_o=0, skid empty, ready_o=1.
- Accept: a beat is accepted when valid_i && ready_o at a rising edge.
- Emit: a beat is emitted when valid_o && ready_i.
- Select: if sel_i < NUM_SRC, data = srcs_i[sel_i]. Otherwise data = 0 and err=1.
- Latency: 1 cycle from accept to valid_o when the output register is empty or draining.
- Storage: output register (main) plus skid register (skid).
  - ready_o = !skid_valid, driven from a flop with no combinational dependence on ready_i.
- States (by occupancy): EMPTY (main and skid empty), ONE (main full), TWO (main and skid full).
  - EMPTY + accept -> ONE.
  - ONE + accept + emit -> ONE; main is loaded with the new beat.
  - ONE + accept + no emit -> TWO; the new beat goes to skid.
  - ONE + emit only -> EMPTY.
  - TWO + emit -> ONE; skid moves to main. No accept is possible in TWO because ready_o=0.
- Ordering: beats leave strictly in acceptance order; no beat is dropped or duplicated.
- Stall: while valid_o && !ready_i, result_o and err_o hold stable.
- valid_i without ready_o: the beat is ignored. Upstream must hold it.
- Reset mid-operation: both entries are discarded and the block returns to EMPTY the next cycle; in-flight beats are lost by design.
- Ready and valid need not arrive together; any order is legal.

Optional Feature:
- Macro: ALU_RESULT_MUX_ZERO_FLAG_EN.
- Defined: adds output port zero_o (1 bit). It is registered alongside result_o and equals (result_o == 0), including error beats where it is 1. It is skid-buffered identically and resets to 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH=64.
  - ALU_SRC_CMP=0, ALU_SRC_PASS=1, ALU_SRC_XOR=2, ALU_SRC_ADD=3.
  - ALU_NUM_SRC=4.
- One sub-module, alu_skid_buf: a generic 2-entry valid/ready skid buffer of payload width WIDTH+1 (+1 when the zero flag is enabled).
- The selector itself stays inline, as combinational logic in front of the skid buffer.

Test Plan:
1. Reset check: assert rst_i 2 cycles. Expect valid_o=0, result_o=0, err_o=0, ready_o=1.
2. Basic select: srcs = {ADD=0x4, XOR=0x3, PASS=0x2, CMP=0x1}, sel_i=2, valid_i for 1 cycle, ready_i=1. Expect valid_o one cycle later with result_o=0x3, err_o=0.
3. Back-pressure: ready_i=0, send sels 0,1,2 back-to-back. Expect ready_o to drop after 2 accepts and result_o to hold 0x1. Then raise ready_i. Expect outputs 0x1, 0x2, 0x3 in order, with the third beat accepted only after ready_o rises.
4. Out-of-range select: NUM_SRC=3, SEL_W=2, sel_i=3. Expect result_o=0, err_o=1. The next beat with sel_i=1 gives err_o=0.
5. Reset mid-operation: with TWO beats held, pulse rst_i for 1 cycle. Expect valid_o=0 and ready_o=1 next cycle, and no stale beat afterward.
6. Random stress and zero flag: random valid_i/ready_i at 50% for 10k cycles, checked against a scoreboard FIFO (order, data, err). With ALU_RESULT_MUX_ZERO_FLAG_EN defined, check zero_o on a 0x0 source and on error beats.
